// File: rtl/bouncing_box_renderer.sv
// Pixel generator placed after vga_controller: a solid box over a flat background,
// moved once per frame during vertical blank and recoloured on every edge bounce.
module bouncing_box_renderer #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned BOX_W    = 32,
  parameter int unsigned BOX_H    = 32,
  parameter int unsigned SPEED_X  = 2,
  parameter int unsigned SPEED_Y  = 1,
  parameter logic [7:0]  BG_COLOR = 8'b000_000_01
) (
  input  logic        i_pix_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [15:0] i_horz_coord,
  input  logic [15:0] i_vert_coord,
  input  logic        i_in_active_area,
  input  logic        i_vert_blank,
  output logic [2:0]  o_red,
  output logic [2:0]  o_green,
  output logic [1:0]  o_blue,
  output logic        o_frame_tick,
  output logic [7:0]  o_bounce_count
);

  localparam logic [15:0] X_MAX = 16'(H_ACTIVE - BOX_W);
  localparam logic [15:0] Y_MAX = 16'(V_ACTIVE - BOX_H);
  localparam logic [15:0] STEP_X = 16'(SPEED_X);
  localparam logic [15:0] STEP_Y = 16'(SPEED_Y);
  localparam logic [15:0] SIZE_X = 16'(BOX_W);
  localparam logic [15:0] SIZE_Y = 16'(BOX_H);

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_t;

  logic        r_blank_prev;
  logic        r_frame_tick;
  logic [15:0] r_box_x;
  logic [15:0] r_box_y;
  dir_t        r_dir_x;
  dir_t        r_dir_y;
  logic [2:0]  r_color;
  logic [7:0]  r_bounce_count;
  logic [2:0]  r_red;
  logic [2:0]  r_green;
  logic [1:0]  r_blue;

  logic        w_tick;
  logic [15:0] w_next_x;
  logic [15:0] w_next_y;
  dir_t        w_next_dir_x;
  dir_t        w_next_dir_y;
  logic        w_bounce_x;
  logic        w_bounce_y;
  logic [2:0]  w_next_color;
  logic        w_inside;
  logic [7:0]  w_box_rgb;

  assign w_tick = i_vert_blank & ~r_blank_prev;

  // Each axis clamps to its limit and reverses on reaching or overshooting it.
  always_comb begin
    w_next_x     = r_box_x;
    w_next_dir_x = r_dir_x;
    w_bounce_x   = 1'b0;
    if (r_dir_x == DIR_INC) begin
      if (r_box_x + STEP_X >= X_MAX) begin
        w_next_x     = X_MAX;
        w_next_dir_x = DIR_DEC;
        w_bounce_x   = 1'b1;
      end else begin
        w_next_x = r_box_x + STEP_X;
      end
    end else begin
      if (r_box_x <= STEP_X) begin
        w_next_x     = '0;
        w_next_dir_x = DIR_INC;
        w_bounce_x   = 1'b1;
      end else begin
        w_next_x = r_box_x - STEP_X;
      end
    end
  end

  always_comb begin
    w_next_y     = r_box_y;
    w_next_dir_y = r_dir_y;
    w_bounce_y   = 1'b0;
    if (r_dir_y == DIR_INC) begin
      if (r_box_y + STEP_Y >= Y_MAX) begin
        w_next_y     = Y_MAX;
        w_next_dir_y = DIR_DEC;
        w_bounce_y   = 1'b1;
      end else begin
        w_next_y = r_box_y + STEP_Y;
      end
    end else begin
      if (r_box_y <= STEP_Y) begin
        w_next_y     = '0;
        w_next_dir_y = DIR_INC;
        w_bounce_y   = 1'b1;
      end else begin
        w_next_y = r_box_y - STEP_Y;
      end
    end
  end

  // Colour index cycles 1..7 so the box is never black.
  assign w_next_color = (r_color == 3'd7) ? 3'd1 : r_color + 3'd1;

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_blank_prev   <= 1'b1;
      r_frame_tick   <= 1'b0;
      r_box_x        <= '0;
      r_box_y        <= '0;
      r_dir_x        <= DIR_INC;
      r_dir_y        <= DIR_INC;
      r_color        <= 3'd7;
      r_bounce_count <= '0;
    end else begin
      r_blank_prev <= i_vert_blank;
      r_frame_tick <= w_tick;
      if (w_tick && i_enable) begin
        r_box_x <= w_next_x;
        r_box_y <= w_next_y;
        r_dir_x <= w_next_dir_x;
        r_dir_y <= w_next_dir_y;
        if (w_bounce_x || w_bounce_y) begin
          r_color        <= w_next_color;
          r_bounce_count <= r_bounce_count + 8'd1;
        end
      end
    end
  end

  assign w_inside = (i_horz_coord >= r_box_x) && (i_horz_coord < r_box_x + SIZE_X) &&
                    (i_vert_coord >= r_box_y) && (i_vert_coord < r_box_y + SIZE_Y);

  assign w_box_rgb = {{3{r_color[0]}}, {3{r_color[1]}}, {2{r_color[2]}}};

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (!i_in_active_area) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (w_inside) begin
      {r_red, r_green, r_blue} <= w_box_rgb;
    end else begin
      {r_red, r_green, r_blue} <= BG_COLOR;
    end
  end

  assign o_red          = r_red;
  assign o_green        = r_green;
  assign o_blue         = r_blue;
  assign o_frame_tick   = r_frame_tick;
  assign o_bounce_count = r_bounce_count;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Directed plus randomized checks of bouncing_box_renderer on a 16x12 screen,
// compared against a plain-arithmetic model of box position, colour and bounces.
module tb_bouncing_box_renderer;

  localparam int HA = 16;
  localparam int VA = 12;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int SX = 3;
  localparam int SY = 2;
  localparam logic [7:0] BG = 8'b000_000_01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] h;
  logic [15:0] v;
  logic        act;
  logic        blank;
  logic [2:0]  o_red;
  logic [2:0]  o_green;
  logic [1:0]  o_blue;
  logic        o_frame_tick;
  logic [7:0]  o_bounce_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int mx, my, mdx, mdy, mc, mcount;

  always #5 clk = ~clk;

  bouncing_box_renderer #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BOX_W(BW), .BOX_H(BH),
    .SPEED_X(SX), .SPEED_Y(SY), .BG_COLOR(BG)
  ) dut (
    .i_pix_clk(clk),
    .i_reset_n(rst_n),
    .i_enable(en),
    .i_horz_coord(h),
    .i_vert_coord(v),
    .i_in_active_area(act),
    .i_vert_blank(blank),
    .o_red(o_red),
    .o_green(o_green),
    .o_blue(o_blue),
    .o_frame_tick(o_frame_tick),
    .o_bounce_count(o_bounce_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mx = 0; my = 0; mdx = 1; mdy = 1; mc = 7; mcount = 0;
  endfunction

  function automatic void model_tick(input bit enable);
    int nx, ny;
    bit b;
    if (!enable) return;
    b = 0;
    nx = mx + mdx * SX;
    if (nx >= HA - BW) begin nx = HA - BW; mdx = -1; b = 1; end
    else if (nx <= 0) begin nx = 0; mdx = 1; b = 1; end
    ny = my + mdy * SY;
    if (ny >= VA - BH) begin ny = VA - BH; mdy = -1; b = 1; end
    else if (ny <= 0) begin ny = 0; mdy = 1; b = 1; end
    mx = nx; my = ny;
    if (b) begin
      mc = (mc % 7) + 1;
      mcount = (mcount + 1) % 256;
    end
  endfunction

  function automatic logic [7:0] model_rgb(input int ph, input int pv, input bit pact);
    int r, g, b;
    if (!pact) return 8'h00;
    if (ph >= mx && ph < mx + BW && pv >= my && pv < my + BH) begin
      r = (mc & 1) != 0 ? 7 : 0;
      g = (mc & 2) != 0 ? 7 : 0;
      b = (mc & 4) != 0 ? 3 : 0;
      return 8'((r << 5) | (g << 2) | b);
    end
    return BG;
  endfunction

  task automatic check_pix(input int ph, input int pv, input bit pact);
    h = 16'(ph); v = 16'(pv); act = pact;
    step();
    chk($sformatf("rgb(%0d,%0d,a%0d)", ph, pv, pact), {8'h00, o_red, o_green, o_blue},
        {8'h00, model_rgb(ph, pv, pact)});
  endtask

  task automatic check_const(input int ph, input int pv, input bit pact, input logic [7:0] exp);
    h = 16'(ph); v = 16'(pv); act = pact;
    step();
    chk($sformatf("rgbk(%0d,%0d,a%0d)", ph, pv, pact), {8'h00, o_red, o_green, o_blue},
        {8'h00, exp});
  endtask

  task automatic scan_frame();
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        check_pix(xx, yy, 1'b1);
  endtask

  // One blank low->high transition; exactly one tick pulse must appear.
  task automatic frame();
    int pulses;
    pulses = 0;
    blank = 1'b0;
    repeat (2) begin step(); if (o_frame_tick) pulses++; end
    blank = 1'b1;
    repeat (3) begin step(); if (o_frame_tick) pulses++; end
    model_tick(en);
    chk("tick_pulses", 16'(pulses), 16'd1);
    chk("bounce_count", {8'h00, o_bounce_count}, 16'(mcount));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; blank = 1'b0; h = '0; v = '0; act = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", {8'h00, o_red, o_green, o_blue}, 16'h0000);
    chk("reset_count", {8'h00, o_bounce_count}, 16'h0000);
    chk("reset_tick", {15'h0, o_frame_tick}, 16'h0000);
    rst_n = 1'b1;

    // render with no tick yet: box at (0,0) in white
    check_const(3, 3, 1'b1, 8'b111_111_11);
    check_const(4, 0, 1'b1, 8'b000_000_01);
    check_const(0, 0, 1'b0, 8'b000_000_00);

    // eight ticks: corner bounce at 4 and 8
    for (int i = 1; i <= 8; i++) begin
      frame();
      scan_frame();
      if (i == 1) begin
        check_const(3, 2, 1'b1, 8'b111_111_11);
        check_const(2, 2, 1'b1, 8'b000_000_01);
      end
      if (i == 4) begin
        check_const(12, 8, 1'b1, 8'b111_000_00);
        chk("count_after4", {8'h00, o_bounce_count}, 16'd1);
      end
      if (i == 8) begin
        check_const(0, 0, 1'b1, 8'b000_111_00);
        check_const(4, 4, 1'b1, 8'b000_000_01);
        chk("count_after8", {8'h00, o_bounce_count}, 16'd2);
      end
    end

    // pause: ticks still pulse, nothing moves
    en = 1'b0;
    repeat (3) frame();
    scan_frame();
    chk("count_paused", {8'h00, o_bounce_count}, 16'd2);
    check_const(0, 0, 1'b1, 8'b000_111_00);
    en = 1'b1;

    // reset released while blank is high: no tick until blank falls and rises
    blank = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_tick_after_rst", {15'h0, o_frame_tick}, 16'h0000);
    end
    chk("count_after_rst", {8'h00, o_bounce_count}, 16'd0);
    frame();
    check_const(3, 2, 1'b1, 8'b111_111_11);

    // mid-frame reset while the box is being drawn
    check_pix(4, 3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {8'h00, o_red, o_green, o_blue}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_const(0, 0, 1'b1, 8'b111_111_11);
    frame();
    scan_frame();

    // randomized frames with random enable and random pixels
    for (int f = 0; f < 40; f++) begin
      en = ($urandom_range(0, 3) != 0);
      frame();
      for (int p = 0; p < 12; p++) begin
        if ($urandom_range(0, 3) != 0)
          check_pix($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), 1'b1);
        else
          check_pix($urandom_range(0, 40), $urandom_range(0, 40), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
